ser_rx_ctrl: RTL and testbench

Serial-receive front end that sits directly upstream of the 8-bit serial-to-parallel shift register (`ser_to_par`). It synchronizes the asynchronous serial line, detects a start bit and samples each data bit at mid-bit. It drives the shift register's `enable`, `serial` and `clear` inputs, and flags frame completion or framing error once the stop bit is checked. The protocol is one start bit (0), 8 data bits LSB-first, and one stop bit (1).

---
 rtl/ser_rx_pkg.sv | 25 ++
 rtl/sync2.sv | 37 +++
 rtl/ser_rx_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ser_rx_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ser_rx_pkg.sv
// ============================================================================
// Module      : ser_rx_pkg
// Description : Shared types and constants for the serial-receive front end.
//               Provides the receive FSM state enum and the data width. The
//               data width must match the downstream shift register
//               (ser_to_par).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ser_rx_pkg;

    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for an asynchronous single-bit input.
//               The reset value is a parameter, so an idle-high line can
//               come out of reset without a false edge.
// Ports       : MHz10 - clock
//               nrst  - synchronous active-low reset
//               i_d   - asynchronous input
//               o_q   - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic MHz10,
    input  logic nrst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge MHz10) begin
        if (!nrst) begin
            r_sync <= {2{RST_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/ser_rx_ctrl.sv
// ============================================================================
// Module      : ser_rx_ctrl
// Description : Serial-receive front end for an 8-bit serial-to-parallel
//               shift register. It synchronizes rx_in and detects a start
//               bit. Each data bit (LSB first) is sampled at mid-bit and
//               handed to the shift register. The stop bit is then checked.
// Ports       : MHz10     - clock
//               nrst      - synchronous active-low reset
//               en        - block enable; low aborts and holds IDLE
//               rx_in     - asynchronous serial line, idles high
//               shift_en  - strobe to shift register enable
//               shift_bit - sampled data bit to shift register serial
//               sr_clear  - strobe to shift register clear
//               byte_done - pulse: frame received, stop bit valid
//               frame_err - pulse: stop bit sampled low
//               busy      - high in START, DATA, STOP
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_rx_ctrl
    import ser_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic MHz10,
    input  logic nrst,
    input  logic en,
    input  logic rx_in,
    output logic shift_en,
    output logic shift_bit,
    output logic sr_clear,
    output logic byte_done,
    output logic frame_err,
    output logic busy
);

    localparam logic [CNT_W-1:0] c_HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_FULL_TC  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic             w_rx_s;

    rx_state_t        r_state,     w_state_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic [IDX_W-1:0] r_bit_idx,   w_idx_nxt;
    logic             r_armed,     w_armed_nxt;
    logic             r_shift_en,  w_shift_en_nxt;
    logic             r_shift_bit, w_shift_bit_nxt;
    logic             r_sr_clear,  w_sr_clear_nxt;
    logic             r_byte_done, w_byte_done_nxt;
    logic             r_frame_err, w_frame_err_nxt;
    logic             r_busy,      w_busy_nxt;

    sync2 #(
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .MHz10 (MHz10),
        .nrst  (nrst),
        .i_d   (rx_in),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge MHz10) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_armed     <= 1'b0;
            r_shift_en  <= 1'b0;
            r_shift_bit <= 1'b0;
            r_sr_clear  <= 1'b0;
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_idx_nxt;
            r_armed     <= w_armed_nxt;
            r_shift_en  <= w_shift_en_nxt;
            r_shift_bit <= w_shift_bit_nxt;
            r_sr_clear  <= w_sr_clear_nxt;
            r_byte_done <= w_byte_done_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + 1'b1;
        w_idx_nxt       = r_bit_idx;
        w_armed_nxt     = r_armed;
        w_shift_en_nxt  = 1'b0;
        w_shift_bit_nxt = r_shift_bit;
        w_sr_clear_nxt  = 1'b0;
        w_byte_done_nxt = 1'b0;
        w_frame_err_nxt = 1'b0;

        if (!en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_armed_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                    // A line must be seen high before a start is accepted,
                    // so a break condition cannot retrigger reception.
                    if (w_rx_s) begin
                        w_armed_nxt = 1'b1;
                    end
                    if (r_armed && !w_rx_s) begin
                        w_state_nxt    = START;
                        w_sr_clear_nxt = 1'b1;
                    end
                end
                START: begin
                    // Half a bit in: confirm the start bit is still low.
                    if (r_cnt == c_HALF_TC) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = w_rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (r_cnt == c_FULL_TC) begin
                        w_cnt_nxt       = '0;
                        w_shift_en_nxt  = 1'b1;
                        w_shift_bit_nxt = w_rx_s;
                        if (r_bit_idx == c_LAST_IDX) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_idx_nxt = r_bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (r_cnt == c_FULL_TC) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                        if (w_rx_s) begin
                            w_byte_done_nxt = 1'b1;
                        end else begin
                            w_frame_err_nxt = 1'b1;
                            w_armed_nxt     = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign shift_en  = r_shift_en;
    assign shift_bit = r_shift_bit;
    assign sr_clear  = r_sr_clear;
    assign byte_done = r_byte_done;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ser_rx_ctrl.sv
// ============================================================================
// Module      : tb_ser_rx_ctrl
// Description : Directed self-checking bench for ser_rx_ctrl with
//               CLKS_PER_BIT = 8. A behavioural 8-bit shift register models
//               ser_to_par downstream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ser_rx_ctrl;

    localparam int CPB = 8;

    logic MHz10 = 1'b0;
    logic nrst  = 1'b0;
    logic en    = 1'b1;
    logic rx_in = 1'b1;
    logic shift_en, shift_bit, sr_clear, byte_done, frame_err, busy;

    logic [7:0] par_out = 8'h00;

    int n_chk = 0;
    int n_err = 0;

    // monitor state
    int         cyc       = 0;
    int         n_shift   = 0;
    int         n_done    = 0;
    int         n_ferr    = 0;
    int         n_clr     = 0;
    int         n_rise    = 0;
    int         n_excl    = 0;
    int         n_nosync  = 0;
    int         rise_cyc  = 0;
    int         shift_cyc = 0;
    int         done_cyc  = 0;
    logic       prev_busy = 1'b0;
    logic [7:0] bits      = 8'h00;
    logic [7:0] last_par  = 8'h00;
    logic [7:0] prev_par  = 8'h00;

    // snapshots taken by the stimulus process
    int fall_cyc, b_shift, b_done, b_ferr, b_clr, b_rise;

    ser_rx_ctrl #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .MHz10     (MHz10),
        .nrst      (nrst),
        .en        (en),
        .rx_in     (rx_in),
        .shift_en  (shift_en),
        .shift_bit (shift_bit),
        .sr_clear  (sr_clear),
        .byte_done (byte_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 MHz10 = ~MHz10;

    // downstream ser_to_par: LSB-first data shifts in from the top
    always @(posedge MHz10) begin
        if (!nrst)         par_out <= 8'h00;
        else if (sr_clear) par_out <= 8'h00;
        else if (shift_en) par_out <= {shift_bit, par_out[7:1]};
    end

    always @(negedge MHz10) begin
        if (shift_en) begin
            n_shift   = n_shift + 1;
            bits      = {shift_bit, bits[7:1]};
            shift_cyc = cyc;
        end
        if (byte_done) begin
            n_done   = n_done + 1;
            prev_par = last_par;
            last_par = par_out;
            done_cyc = cyc;
        end
        if (frame_err) n_ferr = n_ferr + 1;
        if (sr_clear)  n_clr  = n_clr + 1;
        if (busy && !prev_busy) begin
            n_rise   = n_rise + 1;
            rise_cyc = cyc;
            if (!sr_clear) n_nosync = n_nosync + 1;
        end
        if (int'(shift_en) + int'(sr_clear) + int'(byte_done) + int'(frame_err) > 1)
            n_excl = n_excl + 1;
        prev_busy = busy;
        cyc       = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx_in = v;
        repeat (n) begin
            @(posedge MHz10);
            #1;
        end
    endtask

    task automatic snap();
        b_shift = n_shift;
        b_done  = n_done;
        b_ferr  = n_ferr;
        b_clr   = n_clr;
        b_rise  = n_rise;
    endtask

    // start bit followed by the first nbits data bits, LSB first
    task automatic send_bits(input logic [7:0] d, input int nbits);
        fall_cyc = cyc;
        hold(1'b0, CPB);
        for (int i = 0; i < nbits; i++) hold(d[i], CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits(d, 8);
        hold(stop, CPB);
    endtask

    initial begin
        @(posedge MHz10);
        #1;
        nrst = 1'b0;
        hold(1'b1, 3);
        chk("reset_outs", {26'd0, shift_en, shift_bit, sr_clear, byte_done, frame_err, busy}, 32'd0);
        nrst = 1'b1;
        hold(1'b1, 10);

        // valid frame 0xA5
        snap();
        send_frame(8'hA5, 1'b1);
        hold(1'b1, 10);
        chk("a5_shifts",   n_shift - b_shift, 8);
        chk("a5_bits",     bits, 8'hA5);
        chk("a5_done",     n_done - b_done, 1);
        chk("a5_ferr",     n_ferr - b_ferr, 0);
        chk("a5_clr",      n_clr - b_clr, 1);
        chk("a5_par",      last_par, 8'hA5);
        chk("a5_latency",  rise_cyc - fall_cyc, 3);
        chk("a5_done_lag", done_cyc - shift_cyc, CPB);

        // start glitch: 3 cycles low
        snap();
        hold(1'b0, 3);
        hold(1'b1, 20);
        chk("gl_rise",   n_rise - b_rise, 1);
        chk("gl_clr",    n_clr - b_clr, 1);
        chk("gl_shifts", n_shift - b_shift, 0);
        chk("gl_done",   n_done - b_done, 0);
        chk("gl_idle",   busy, 0);

        // 0x3C with low stop bit, then line held low
        snap();
        send_frame(8'h3C, 1'b0);
        hold(1'b0, 40);
        chk("fe_shifts", n_shift - b_shift, 8);
        chk("fe_bits",   bits, 8'h3C);
        chk("fe_ferr",   n_ferr - b_ferr, 1);
        chk("fe_done",   n_done - b_done, 0);
        chk("fe_norest", n_rise - b_rise, 1);
        hold(1'b1, 16);
        chk("fe_rearm_nostart", n_rise - b_rise, 1);

        // back-to-back 0x12, 0xEF
        snap();
        send_frame(8'h12, 1'b1);
        send_frame(8'hEF, 1'b1);
        hold(1'b1, 10);
        chk("bb_done",  n_done - b_done, 2);
        chk("bb_clr",   n_clr - b_clr, 2);
        chk("bb_par1",  prev_par, 8'h12);
        chk("bb_par2",  last_par, 8'hEF);
        chk("bb_ferr",  n_ferr - b_ferr, 0);

        // reset abort after bit 3
        snap();
        send_bits(8'h5A, 4);
        nrst  = 1'b0;
        rx_in = 1'b1;
        @(posedge MHz10);
        #1;
        nrst = 1'b1;
        chk("rst_outs", {26'd0, shift_en, shift_bit, sr_clear, byte_done, frame_err, busy}, 32'd0);
        hold(1'b1, 20);
        chk("rst_nodone", (n_done - b_done) + (n_ferr - b_ferr), 0);
        snap();
        send_frame(8'h81, 1'b1);
        hold(1'b1, 10);
        chk("rst_81_done", n_done - b_done, 1);
        chk("rst_81_par",  last_par, 8'h81);

        // enable abort after bit 5
        snap();
        send_bits(8'h5A, 6);
        en = 1'b0;
        hold(1'b1, 2);
        chk("en_idle", busy, 0);
        en = 1'b1;
        hold(1'b1, 20);
        chk("en_nodone", (n_done - b_done) + (n_ferr - b_ferr), 0);
        snap();
        send_frame(8'h81, 1'b1);
        hold(1'b1, 10);
        chk("en_81_done", n_done - b_done, 1);
        chk("en_81_par",  last_par, 8'h81);
        chk("en_81_ferr", n_ferr - b_ferr, 0);

        chk("mutex",       n_excl, 0);
        chk("clr_w_busy",  n_nosync, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
